mod_exp_ctrl: RTL and testbench

Left-to-right square-and-multiply controller for RSA/ECC modular exponentiation, result = base^exp mod m. Sits directly upstream of the Montgomery multiplier and is its only client. It drives the multiplier's operand and start inputs and consumes its result and done flag. It performs the conversion into and out of the Montgomery domain and presents a registered result with a one-cycle done pulse.

---
 rtl/mod_exp_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_mod_exp_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply controller for base^exp mod m over a Montgomery multiplier.
// Optional build macro MODEXP_LZ_SKIP_EN: walk past leading zero exponent bits without calls.
module mod_exp_ctrl #(
  parameter int           K    = 192,
  parameter int           LOGK = 8,
  parameter logic [K-1:0] R2   = 192'h0000000000000001_0000000000000002_0000000000000001
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [K-1:0] base,
  input  logic [K-1:0] exp,
  output logic [K-1:0] result,
  output logic         busy,
  output logic         done,
  output logic [K-1:0] mult_x,
  output logic [K-1:0] mult_y,
  output logic         mult_start,
  input  logic [K-1:0] mult_z,
  input  logic         mult_done
);
  typedef enum logic [2:0] {IDLE, PRE_B, PRE_A, SCAN, SQR, MUL, POST, FIN} state_t;
  typedef enum logic [1:0] {PH_SETUP, PH_LAUNCH, PH_WAIT} phase_t;

  localparam logic [K-1:0]    ONE     = K'(1);
  localparam logic [LOGK-1:0] IDX_TOP = LOGK'(K-1);
  localparam logic [LOGK-1:0] IDX_ONE = LOGK'(1);

  state_t          state, state_nxt;
  phase_t          phase, phase_nxt;
  logic [K-1:0]    b_reg, b_nxt, e_reg, e_nxt, bm, bm_nxt, acc, acc_nxt;
  logic [K-1:0]    result_nxt, x_nxt, y_nxt, op_x, op_y;
  logic [LOGK-1:0] idx, idx_nxt;
  logic            busy_nxt, done_nxt, ms_nxt;
  logic            in_call, call_done, idx_zero, e_bit;
`ifdef MODEXP_LZ_SKIP_EN
  logic            lead, lead_nxt;
`endif

  assign in_call  = (state == PRE_B) || (state == PRE_A) || (state == SQR) ||
                    (state == MUL) || (state == POST);
  assign idx_zero = (idx == '0);
  assign e_bit    = e_reg[idx];

  // Operand pair for the call owned by the current state; latched in the setup cycle.
  always_comb begin
    op_x = '0;
    op_y = '0;
    case (state)
      PRE_B:   begin op_x = b_reg; op_y = R2;  end
      PRE_A:   begin op_x = ONE;   op_y = R2;  end
      SQR:     begin op_x = acc;   op_y = acc; end
      MUL:     begin op_x = acc;   op_y = bm;  end
      POST:    begin op_x = acc;   op_y = ONE; end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    phase_nxt  = phase;
    b_nxt      = b_reg;
    e_nxt      = e_reg;
    bm_nxt     = bm;
    acc_nxt    = acc;
    idx_nxt    = idx;
    result_nxt = result;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    x_nxt      = mult_x;
    y_nxt      = mult_y;
    ms_nxt     = mult_start;
    call_done  = 1'b0;
`ifdef MODEXP_LZ_SKIP_EN
    lead_nxt   = lead;
`endif

    // Call handshake: start is held until the multiplier drops done, then we wait for it to rise.
    if (in_call) begin
      case (phase)
        PH_SETUP: begin
          x_nxt     = op_x;
          y_nxt     = op_y;
          ms_nxt    = 1'b1;
          phase_nxt = PH_LAUNCH;
        end
        PH_LAUNCH: if (!mult_done) begin
          ms_nxt    = 1'b0;
          phase_nxt = PH_WAIT;
        end
        PH_WAIT: if (mult_done) begin
          call_done = 1'b1;
          phase_nxt = PH_SETUP;
        end
        default: phase_nxt = PH_SETUP;
      endcase
    end

    case (state)
      IDLE: if (start) begin
        b_nxt     = base;
        e_nxt     = exp;
        idx_nxt   = IDX_TOP;
        busy_nxt  = 1'b1;
        state_nxt = PRE_B;
`ifdef MODEXP_LZ_SKIP_EN
        lead_nxt  = 1'b1;
`endif
      end
      PRE_B: if (call_done) begin
        bm_nxt    = mult_z;
        state_nxt = PRE_A;
      end
      PRE_A: if (call_done) begin
        acc_nxt   = mult_z;
`ifdef MODEXP_LZ_SKIP_EN
        state_nxt = (e_reg == '0) ? POST : SCAN;
`else
        state_nxt = SCAN;
`endif
      end
      SCAN: begin
`ifdef MODEXP_LZ_SKIP_EN
        // A nonzero exponent guarantees the walk stops on its top one before idx reaches 0.
        if (lead && !e_bit) begin
          idx_nxt = idx - IDX_ONE;
        end else begin
          lead_nxt  = 1'b0;
          state_nxt = SQR;
        end
`else
        state_nxt = SQR;
`endif
      end
      SQR: if (call_done) begin
        acc_nxt = mult_z;
        if (e_bit) begin
          state_nxt = MUL;
        end else if (idx_zero) begin
          state_nxt = POST;
        end else begin
          idx_nxt   = idx - IDX_ONE;
          state_nxt = SCAN;
        end
      end
      MUL: if (call_done) begin
        acc_nxt = mult_z;
        if (idx_zero) begin
          state_nxt = POST;
        end else begin
          idx_nxt   = idx - IDX_ONE;
          state_nxt = SCAN;
        end
      end
      POST: if (call_done) begin
        result_nxt = mult_z;
        done_nxt   = 1'b1;
        state_nxt  = FIN;
      end
      FIN: begin
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      phase      <= PH_SETUP;
      b_reg      <= '0;
      e_reg      <= '0;
      bm         <= '0;
      acc        <= '0;
      idx        <= '0;
      result     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      mult_x     <= '0;
      mult_y     <= '0;
      mult_start <= 1'b0;
`ifdef MODEXP_LZ_SKIP_EN
      lead       <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      phase      <= phase_nxt;
      b_reg      <= b_nxt;
      e_reg      <= e_nxt;
      bm         <= bm_nxt;
      acc        <= acc_nxt;
      idx        <= idx_nxt;
      result     <= result_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      mult_x     <= x_nxt;
      mult_y     <= y_nxt;
      mult_start <= ms_nxt;
`ifdef MODEXP_LZ_SKIP_EN
      lead       <= lead_nxt;
`endif
    end
  end
endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Bench for mod_exp_ctrl: behavioural Montgomery multiplier stub plus plain modexp reference model.
module tb_mod_exp_ctrl;
  localparam int K = 192;
  localparam logic [K-1:0]   M  = 192'hFFFFFFFFFFFFFFFF_FFFFFFFFFFFFFFFE_FFFFFFFFFFFFFFFF;
  localparam logic [2*K-1:0] MW = {{K{1'b0}}, M};

  logic         clk, rst, start;
  logic [K-1:0] op_base, op_exp, result, mult_x, mult_y, mult_z;
  logic         busy, done, mult_start, mult_done;

  mod_exp_ctrl #(.K(K), .LOGK(8)) dut (
    .clk(clk), .reset(rst), .start(start), .base(op_base), .exp(op_exp),
    .result(result), .busy(busy), .done(done),
    .mult_x(mult_x), .mult_y(mult_y), .mult_start(mult_start),
    .mult_z(mult_z), .mult_done(mult_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0, passes = 0;
  task automatic chk(input string name, input logic [K-1:0] act, input logic [K-1:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h want %0h", name, act, req);
  endtask

  // x*y*2^-K mod m, bit-serial
  function automatic logic [K-1:0] mont(input logic [K-1:0] x, input logic [K-1:0] y);
    logic [K+1:0] t = '0;
    for (int i = 0; i < K; i++) begin
      if (x[i]) t = t + {2'b00, y};
      if (t[0]) t = t + {2'b00, M};
      t = t >> 1;
    end
    if (t >= {2'b00, M}) t = t - {2'b00, M};
    return t[K-1:0];
  endfunction

  function automatic logic [K-1:0] modexp(input logic [K-1:0] b, input logic [K-1:0] e);
    logic [2*K-1:0] r, bb;
    r = '0; r[0] = 1'b1;
    bb = {{K{1'b0}}, b};
    for (int i = K-1; i >= 0; i--) begin
      r = (r * r) % MW;
      if (e[i]) r = (r * bb) % MW;
    end
    return r[K-1:0];
  endfunction

  function automatic int exp_calls(input logic [K-1:0] e);
`ifdef MODEXP_LZ_SKIP_EN
    int top = -1;
    for (int i = 0; i < K; i++) if (e[i]) top = i;
    return 3 + top + 1 + $countones(e);
`else
    return 3 + K + $countones(e);
`endif
  endfunction

  // Multiplier stub with 1..3 cycle latency and handshake/operand-stability monitor
  logic         mb_busy;
  logic [1:0]   mb_cnt;
  logic [K-1:0] lx, ly;
  logic         ms_prev, launch_prev;
  int           rises, viol;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mb_busy <= 1'b0; mb_cnt <= '0; mult_done <= 1'b1; mult_z <= '0;
      lx <= '0; ly <= '0; ms_prev <= 1'b0; launch_prev <= 1'b0; rises <= 0; viol <= 0;
    end else begin
      ms_prev     <= mult_start;
      launch_prev <= mult_start && !mult_done;
      if (mult_start && !ms_prev) rises <= rises + 1;
      if ((mult_start && !mult_done && launch_prev) || (mult_start && !ms_prev && mb_busy) ||
          (mb_busy && (mult_x != lx || mult_y != ly)))
        viol <= viol + 1;
      if (!mb_busy) begin
        if (mult_start) begin
          mb_busy <= 1'b1; lx <= mult_x; ly <= mult_y; mult_done <= 1'b0;
          mb_cnt <= 2'($urandom_range(2, 0));
        end
      end else if (mb_cnt == 2'd0) begin
        mult_z <= mont(lx, ly); mult_done <= 1'b1; mb_busy <= 1'b0;
      end else begin
        mb_cnt <= mb_cnt - 2'd1;
      end
    end
  end

  // Compare process: tracks accepted operations and checks outputs every cycle
  bit           inflight = 0, acc_next = 0;
  logic [K-1:0] held = '0, cur = '0, lb = '0, le = '0, e_op = '0;
  int           r0 = 0, v0 = 0, ndone = 0, last_calls = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        inflight = 0; acc_next = 0; held = '0;
      end else begin
        if (acc_next) begin
          inflight = 1; cur = modexp(lb, le); e_op = le; r0 = rises; v0 = viol;
        end
        chk("busy", K'(busy), K'(inflight));
        if (done) begin
          chk("done_in_flight", K'(inflight), K'(1));
          if (inflight) begin
            last_calls = rises - r0;
            chk("result", result, cur);
            chk("call_count", K'(last_calls), K'(exp_calls(e_op)));
            chk("handshake", K'(viol - v0), K'(0));
            held = cur;
            inflight = 0;
            ndone++;
          end
        end else begin
          chk("result_hold", result, held);
        end
        acc_next = start && !inflight && !done;
        lb = op_base; le = op_exp;
      end
    end
  end

  task automatic wait_done(input int n0);
    int cyc = 0;
    while (ndone == n0 && cyc < 20000) begin @(posedge clk); cyc++; end
    chk("op_done", K'(ndone - n0), K'(1));
  endtask

  task automatic run_op(input logic [K-1:0] b, input logic [K-1:0] e);
    int n0 = ndone;
    @(posedge clk); #1; start = 1'b1; op_base = b; op_exp = e;
    @(posedge clk); #1; start = 1'b0;
    wait_done(n0);
  endtask

  function automatic logic [K-1:0] rand_k();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_result"}, result, '0);
    chk({tag, "_busy"}, K'(busy), K'(0));
    chk({tag, "_done"}, K'(done), K'(0));
    chk({tag, "_mult_start"}, K'(mult_start), K'(0));
    chk({tag, "_mult_x"}, mult_x, '0);
    chk({tag, "_mult_y"}, mult_y, '0);
  endtask

  initial begin
    logic [K-1:0] b, e;
    int n0, cyc;
    rst = 1'b1; start = 1'b0; op_base = '0; op_exp = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("rst0");
    rst = 1'b0;

    run_op(K'(2), K'(3));
    chk("res_2_3", result, K'(8));
`ifdef MODEXP_LZ_SKIP_EN
    chk("calls_2_3", K'(last_calls), K'(7));
`else
    chk("calls_2_3", K'(last_calls), K'(197));
`endif
    run_op(K'(5), K'(0));
    chk("res_5_0", result, K'(1));
`ifdef MODEXP_LZ_SKIP_EN
    chk("calls_5_0", K'(last_calls), K'(3));
`else
    chk("calls_5_0", K'(last_calls), K'(195));
`endif
    run_op(K'(0), K'(5));
    chk("res_0_5", result, K'(0));
    run_op(K'(3), M - K'(1));
    chk("res_fermat", result, K'(1));

    // start during busy is dropped
    n0 = ndone;
    @(posedge clk); #1; start = 1'b1; op_base = K'(2); op_exp = K'(3);
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    #1; start = 1'b1; op_base = K'(7); op_exp = K'(9);
    repeat (3) @(posedge clk);
    #1; start = 1'b0;
    wait_done(n0);
    repeat (30) @(posedge clk);
    chk("ignored_single_done", K'(ndone - n0), K'(1));
    chk("ignored_res", result, K'(8));

    for (int i = 0; i < 6; i++) begin
      b = rand_k();
      if (b >= M) b = b - M;
      if (i == 5) b = M - K'(1);
      e = rand_k();
      if (i % 3 == 1) e = K'($urandom_range(255, 0));
      if (i % 3 == 2) e = e >> $urandom_range(180, 100);
      run_op(b, e);
    end

    // reset while the first squaring call is in flight
    b = rand_k();
    if (b >= M) b = b - M;
    @(posedge clk); #1; start = 1'b1; op_base = b; op_exp = {K{1'b1}};
    @(posedge clk); #1; start = 1'b0;
    cyc = 0;
    while (!(mult_start && mult_x == mult_y && busy) && cyc < 5000) begin
      @(posedge clk); #1; cyc++;
    end
    chk("reached_sqr", K'(mult_start && mult_x == mult_y), K'(1));
    #2; rst = 1'b1;
    #1;
    chk_reset_outputs("rst_mid");
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    run_op(K'(2), K'(10));
    chk("res_2_10", result, K'(1024));

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
